// File: rtl/mem_port_arbiter.sv
// Arbiter for the single data port of the shared RAM: N requesters, fixed-priority or
// round-robin grant, exclusive lock with idle timeout, and per-port read-response routing.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RR_EN        = 1,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_en,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS-1:0]        req_lock,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS*2-1:0]      req_byte_sel,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        lock_active,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic [1:0]                  ram_byte_sel,
    input  logic [DATA_W-1:0]           ram_rdata
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    logic [PTR_W-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                     owner_q, owner_d;
    logic                                 lock_q, lock_d;
    logic [CNT_W-1:0]                     idle_q, idle_d;
    logic [RD_LATENCY-1:0][NUM_PORTS-1:0] rsp_pipe_q, rsp_pipe_d;
    logic                                 gnt_any_c;
    logic [PTR_W-1:0]                     gnt_idx_c;
    logic [NUM_PORTS-1:0]                 rd_tag_c;

    // Winner selection: owner only while locked, otherwise search from the rotating pointer.
    always_comb begin : arb_comb
        int unsigned idx;
        idx       = 0;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        if (lock_q) begin
            if (req_en[owner_q]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = owner_q;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                idx = k + ((RR_EN != 0) ? 32'(rr_ptr_q) : 32'd0);
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (!gnt_any_c && req_en[PTR_W'(idx)]) begin
                    gnt_any_c = 1'b1;
                    gnt_idx_c = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin : port_mux_comb
        gnt          = '0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_byte_sel = '0;
        if (gnt_any_c) begin
            gnt[gnt_idx_c] = 1'b1;
            ram_en         = 1'b1;
            ram_we         = req_we[gnt_idx_c];
            ram_addr       = req_addr[32'(gnt_idx_c) * ADDR_W +: ADDR_W];
            ram_wdata      = req_wdata[32'(gnt_idx_c) * DATA_W +: DATA_W];
            ram_byte_sel   = req_byte_sel[32'(gnt_idx_c) * 2 +: 2];
        end
    end

    // Lock ownership, idle timeout and round-robin pointer update.
    always_comb begin : next_state_comb
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        lock_d   = lock_q;
        idle_d   = idle_q;
        if (gnt_any_c) begin
            rr_ptr_d = (32'(gnt_idx_c) == NUM_PORTS - 1) ? '0 : gnt_idx_c + PTR_W'(1);
        end
        if (lock_q) begin
            if (req_en[owner_q]) begin
                idle_d = '0;
                if (!req_lock[owner_q]) begin
                    lock_d  = 1'b0;
                    owner_d = '0;
                end
            end else if (LOCK_TIMEOUT != 0) begin
                if (32'(idle_q) + 32'd1 >= LOCK_TIMEOUT) begin
                    lock_d  = 1'b0;
                    owner_d = '0;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end
        end else if (gnt_any_c && req_lock[gnt_idx_c]) begin
            lock_d  = 1'b1;
            owner_d = gnt_idx_c;
            idle_d  = '0;
        end
    end

    // Writes enter the response pipe as an all-zero tag so they never raise rsp_valid.
    assign rd_tag_c = (gnt_any_c && !req_we[gnt_idx_c]) ? gnt : '0;

    if (RD_LATENCY > 1) begin : g_pipe_deep
        assign rsp_pipe_d = {rsp_pipe_q[RD_LATENCY-2:0], rd_tag_c};
    end else begin : g_pipe_one
        assign rsp_pipe_d = rd_tag_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_ff
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_q     <= 1'b0;
            idle_q     <= '0;
            rsp_pipe_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            idle_q     <= idle_d;
            rsp_pipe_q <= rsp_pipe_d;
        end
    end

    assign rsp_valid   = rsp_pipe_q[RD_LATENCY-1];
    assign rsp_rdata   = ram_rdata;
    assign lock_active = lock_q;

endmodule
